scale_demux: RTL

- Registered 1-to-2 stream demultiplexer. It is the counterpart of the scale_mux 2-to-1 selector.
- Accepts one input byte stream with a valid/ready handshake and steers each byte to output A or B according to i_sel_a.
- Each output has a small elastic buffer so that backpressure on one output does not stall traffic bound for the other.
- Sits after scale_mux-style datapaths wherever one source must fan out to two consumers.

---
 rtl/scale_pkg.sv | 11 +
 rtl/scale_fifo.sv | 63 ++++++
 rtl/scale_demux.sv | 82 ++++++++
 3 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the scale_demux stream demultiplexer.
// Imported by the buffer and top-level files.
package scale_pkg;

   localparam int DATA_W = 8;

   typedef logic [7:0] byte_t;

   typedef enum logic {SEL_B = 1'b0, SEL_A = 1'b1} sel_e;

endpackage

// File: rtl/scale_fifo.sv
// Small elastic buffer: DEPTH entries, separate occupancy counter, wrapping pointers.
// When empty, data_out keeps showing the last popped value.
module scale_fifo
   import scale_pkg::*;
#(
   parameter int width = DATA_W,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push,
   input  logic [width-1:0] data_in,
   output logic             full,
   input  logic             pop,
   output logic [width-1:0] data_out,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [width-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [width-1:0] last_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign data_out = empty ? last_q : mem[rd_ptr];

   // Storage is only written on an accepted push, so it never needs a reset.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/scale_demux.sv
// Registered 1-to-2 byte stream demultiplexer with an elastic buffer per output
// and a wrapping delivered-byte counter per output.
module scale_demux
   import scale_pkg::*;
#(
   parameter int size  = 7,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [size:0]    i_in,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic             i_sel_a,
   output logic [size:0]    o_out_a,
   output logic             o_out_a_valid,
   input  logic             i_out_a_ready,
   output logic [size:0]    o_out_b,
   output logic             o_out_b_valid,
   input  logic             i_out_b_ready,
   output logic [CNT_W-1:0] o_cnt_a,
   output logic [CNT_W-1:0] o_cnt_b
);

   localparam int W = size + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; ready never depends on the same-side valid, and input ready never
   // depends on the output readies (only on select and registered occupancy).
   sel_e sel;
   logic rdy_en;
   logic full_a, full_b, empty_a, empty_b;
   logic push_a, push_b, pop_a, pop_b;

   assign sel        = i_sel_a ? SEL_A : SEL_B;
   assign o_in_ready = rdy_en && ((sel == SEL_A) ? !full_a : !full_b);
   assign push_a     = i_in_valid && o_in_ready && (sel == SEL_A);
   assign push_b     = i_in_valid && o_in_ready && (sel == SEL_B);

   assign o_out_a_valid = !empty_a;
   assign o_out_b_valid = !empty_b;
   assign pop_a         = o_out_a_valid && i_out_a_ready;
   assign pop_b         = o_out_b_valid && i_out_b_ready;

   scale_fifo #(.width(W), .DEPTH(DEPTH)) u_fifo_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push_a),
      .data_in (i_in),
      .full    (full_a),
      .pop     (pop_a),
      .data_out(o_out_a),
      .empty   (empty_a)
   );

   scale_fifo #(.width(W), .DEPTH(DEPTH)) u_fifo_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push_b),
      .data_in (i_in),
      .full    (full_b),
      .pop     (pop_b),
      .data_out(o_out_b),
      .empty   (empty_b)
   );

   // Input ready is held low until the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_en  <= 1'b0;
         o_cnt_a <= '0;
         o_cnt_b <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (pop_a) o_cnt_a <= o_cnt_a + CNT_ONE;
         if (pop_b) o_cnt_b <= o_cnt_b + CNT_ONE;
      end
   end

endmodule
